// File: rtl/w_ctrl_level_if.sv
// Write-side FIFO controller bus: write request, overflow clear, read pointer in;
// write pointer, RAM address, level and flags out.
interface w_ctrl_level_if #(
   parameter int ADDRESS_SIZE = 4
);
   logic                    w_en;
   logic                    ovf_clr;
   logic [ADDRESS_SIZE:0]   r_ptr;
   logic [ADDRESS_SIZE:0]   w_ptr;
   logic [ADDRESS_SIZE-1:0] w_addr;
   logic                    w_full;
   logic                    w_almost_full;
   logic [ADDRESS_SIZE:0]   w_level;
   logic                    w_overflow;

   modport master (
      output w_en, ovf_clr, r_ptr,
      input  w_ptr, w_addr, w_full, w_almost_full, w_level, w_overflow
   );

   modport slave (
      input  w_en, ovf_clr, r_ptr,
      output w_ptr, w_addr, w_full, w_almost_full, w_level, w_overflow
   );
endinterface

// File: rtl/w_ctrl_level.sv
// Async FIFO write-domain controller: binary/Gray write pointer, read-pointer
// synchroniser, registered fill level, almost-full, full and sticky overflow.
module w_ctrl_level #(
   parameter int ADDRESS_SIZE = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int AF_THRESHOLD = (1 << ADDRESS_SIZE) - 2
) (
   input logic           clk,
   input logic           rst,
   w_ctrl_level_if.slave bus
);
   localparam int AW = ADDRESS_SIZE;
   localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] AF_LVL = AF_THRESHOLD[AW:0];

   logic [AW:0] w_bin_q,   w_bin_d;
   logic [AW:0] w_ptr_q,   w_ptr_d;
   logic [AW:0] w_level_q, w_level_d;
   logic        w_full_q,  w_full_d;
   logic        w_af_q,    w_af_d;
   logic        w_ovf_q,   w_ovf_d;
   logic [AW:0] sync_q [SYNC_STAGES];
   logic [AW:0] sync_d [SYNC_STAGES];

   logic        accept;
   logic [AW:0] wq_rptr;
   logic [AW:0] rq_bin;

   assign wq_rptr = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: each variable is assigned on every pass through this block, so no latch is inferred.
      accept  = bus.w_en & ~w_full_q;
      w_bin_d = w_bin_q + {{AW{1'b0}}, accept};
      w_ptr_d = w_bin_d ^ (w_bin_d >> 1);

      sync_d[0] = bus.r_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      // Gray to binary: bit i is the XOR of every Gray bit at or above i.
      for (int i = 0; i <= AW; i++) begin
         rq_bin[i] = ^(wq_rptr >> i);
      end

      // A stale read pointer can only make this larger, so flags stay pessimistic.
      w_level_d = w_bin_d - rq_bin;
      w_full_d  = (w_level_d == DEPTH);
      w_af_d    = (w_level_d >= AF_LVL);

      if (bus.w_en && w_full_q) begin
         w_ovf_d = 1'b1;
      end else if (bus.ovf_clr) begin
         w_ovf_d = 1'b0;
      end else begin
         w_ovf_d = w_ovf_q;
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_bin_q   <= '0;
         w_ptr_q   <= '0;
         w_level_q <= '0;
         w_full_q  <= 1'b0;
         w_af_q    <= 1'b0;
         w_ovf_q   <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         w_bin_q   <= w_bin_d;
         w_ptr_q   <= w_ptr_d;
         w_level_q <= w_level_d;
         w_full_q  <= w_full_d;
         w_af_q    <= w_af_d;
         w_ovf_q   <= w_ovf_d;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign bus.w_ptr         = w_ptr_q;
   assign bus.w_addr        = w_bin_q[AW-1:0];
   assign bus.w_full        = w_full_q;
   assign bus.w_almost_full = w_af_q;
   assign bus.w_level       = w_level_q;
   assign bus.w_overflow    = w_ovf_q;
endmodule

// File: tb/tb_w_ctrl_level.sv
// Scoreboard bench for w_ctrl_level (ADDRESS_SIZE=3, SYNC_STAGES=2, AF_THRESHOLD=6):
// the driver queues expected post-edge outputs, a monitor pops and compares them.
module tb_w_ctrl_level;
   typedef struct {
      string      name;
      logic [5:0] mask;   // {ovf, level, af, full, addr, ptr}
      logic [3:0] ptr;
      logic [2:0] addr;
      logic       full;
      logic       af;
      logic [3:0] level;
      logic       ovf;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb_q [$];

   w_ctrl_level_if #(.ADDRESS_SIZE(3)) bus ();

   w_ctrl_level #(
      .ADDRESS_SIZE(3),
      .SYNC_STAGES (2),
      .AF_THRESHOLD(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] gray(input int b);
      logic [3:0] v;
      v = b[3:0];
      return v ^ (v >> 1);
   endfunction

   function automatic exp_t e_all(input string n, input logic [3:0] ptr, input logic [2:0] addr,
                                  input logic full, input logic af, input logic [3:0] lvl,
                                  input logic ovf);
      exp_t e;
      e.name  = n;
      e.mask  = 6'h3f;
      e.ptr   = ptr;
      e.addr  = addr;
      e.full  = full;
      e.af    = af;
      e.level = lvl;
      e.ovf   = ovf;
      return e;
   endfunction

   // One cycle of stimulus: inputs change at the falling edge, expectation is for the next rising edge.
   task automatic cyc(input logic en, input logic clr, input logic [3:0] rp, input exp_t e);
      @(negedge clk);
      bus.w_en    = en;
      bus.ovf_clr = clr;
      bus.r_ptr   = rp;
      sb_q.push_back(e);
   endtask

   // Monitor: samples 2 time units after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.mask[0]) check({e.name, ".w_ptr"},         32'(bus.w_ptr),         32'(e.ptr));
            if (e.mask[1]) check({e.name, ".w_addr"},        32'(bus.w_addr),        32'(e.addr));
            if (e.mask[2]) check({e.name, ".w_full"},        32'(bus.w_full),        32'(e.full));
            if (e.mask[3]) check({e.name, ".w_almost_full"}, 32'(bus.w_almost_full), 32'(e.af));
            if (e.mask[4]) check({e.name, ".w_level"},       32'(bus.w_level),       32'(e.level));
            if (e.mask[5]) check({e.name, ".w_overflow"},    32'(bus.w_overflow),    32'(e.ovf));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] fill_ptr [8];
      int         n;
      fill_ptr = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      checks = 0;
      errors = 0;

      rst         = 1'b1;
      bus.w_en    = 1'b0;
      bus.ovf_clr = 1'b0;
      bus.r_ptr   = '0;
      #3;
      check("reset.w_ptr",   32'(bus.w_ptr),   32'h0);
      check("reset.w_level", 32'(bus.w_level), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'b0000, e_all("idle", 4'b0000, 3'd0, 0, 0, 4'd0, 0));

      // Fill: almost-full on the 6th write, full on the 8th with w_ptr = 1100.
      for (int k = 1; k <= 8; k++)
         cyc(1'b1, 1'b0, 4'b0000, e_all("fill", fill_ptr[k-1], 3'(k), k == 8, k >= 6, 4'(k), 0));

      cyc(1'b1, 1'b0, 4'b0000, e_all("rej1",     4'b1100, 3'd0, 1, 1, 4'd8, 1));
      cyc(1'b1, 1'b1, 4'b0000, e_all("set_wins", 4'b1100, 3'd0, 1, 1, 4'd8, 1));
      cyc(1'b1, 1'b0, 4'b0000, e_all("rej3",     4'b1100, 3'd0, 1, 1, 4'd8, 1));
      cyc(1'b0, 1'b1, 4'b0000, e_all("ovf_clr",  4'b1100, 3'd0, 1, 1, 4'd8, 0));

      // Read pointer to binary 2: level drops to 6 exactly two edges later.
      cyc(1'b0, 1'b0, 4'b0011, e_all("rd_m0", 4'b1100, 3'd0, 1, 1, 4'd8, 0));
      cyc(1'b0, 1'b0, 4'b0011, e_all("rd_m1", 4'b1100, 3'd0, 1, 1, 4'd8, 0));
      cyc(1'b0, 1'b0, 4'b0011, e_all("rd_m2", 4'b1100, 3'd0, 0, 1, 4'd6, 0));

      // Drain: read pointer to binary 8 (Gray 1100).
      cyc(1'b0, 1'b0, 4'b1100, e_all("drain0", 4'b1100, 3'd0, 0, 1, 4'd6, 0));
      cyc(1'b0, 1'b0, 4'b1100, e_all("drain1", 4'b1100, 3'd0, 0, 1, 4'd6, 0));
      cyc(1'b0, 1'b0, 4'b1100, e_all("drain2", 4'b1100, 3'd0, 0, 0, 4'd0, 0));

      // Wrap-around: the reader trails one entry behind, so the level settles at 3.
      for (int j = 1; j <= 20; j++) begin
         n = 8 + j;
         cyc(1'b1, 1'b0, gray(n - 1),
             e_all("wrap", gray(n), 3'(n % 8), 0, 0, 4'((j < 3) ? j : 3), 0));
      end

      // Reader stops at binary 12; five more writes bring the level to 5.
      cyc(1'b1, 1'b0, 4'b1010, e_all("lvl5_w1", 4'b1011, 3'd5, 0, 0, 4'd3, 0));
      cyc(1'b1, 1'b0, 4'b1010, e_all("lvl5_w2", 4'b1001, 3'd6, 0, 0, 4'd3, 0));
      cyc(1'b1, 1'b0, 4'b1010, e_all("lvl5_w3", 4'b1000, 3'd7, 0, 0, 4'd3, 0));
      cyc(1'b1, 1'b0, 4'b1010, e_all("lvl5_w4", 4'b0000, 3'd0, 0, 0, 4'd4, 0));
      cyc(1'b1, 1'b0, 4'b1010, e_all("lvl5_w5", 4'b0001, 3'd1, 0, 0, 4'd5, 0));

      // Asynchronous reset between edges.
      @(negedge clk);
      bus.w_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst.w_ptr",         32'(bus.w_ptr),         32'h0);
      check("async_rst.w_addr",        32'(bus.w_addr),        32'h0);
      check("async_rst.w_full",        32'(bus.w_full),        32'h0);
      check("async_rst.w_almost_full", 32'(bus.w_almost_full), 32'h0);
      check("async_rst.w_level",       32'(bus.w_level),       32'h0);
      check("async_rst.w_overflow",    32'(bus.w_overflow),    32'h0);
      @(negedge clk);
      rst       = 1'b0;
      bus.r_ptr = '0;

      cyc(1'b1, 1'b0, 4'b0000, e_all("post_rst_w1", 4'b0001, 3'd1, 0, 0, 4'd1, 0));
      cyc(1'b1, 1'b0, 4'b0000, e_all("post_rst_w2", 4'b0011, 3'd2, 0, 0, 4'd2, 0));
      @(negedge clk);
      bus.w_en = 1'b0;

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
      #3;
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
